// File: rtl/ab_req_merger.sv
// A/B request merger: buffers address requests and data beats separately, then
// emits one write beat per data word with an incrementing address.
module ab_req_merger #(
  parameter int ADDR_W     = 12,
  parameter int LEN_W      = 4,
  parameter int DATA_W     = 24,
  parameter int REQ_DEPTH  = 4,
  parameter int DATA_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid_Addr,
  input  logic [ADDR_W-1:0] Address,
  input  logic [LEN_W-1:0]  Length,
  input  logic              Valid_Data,
  input  logic [DATA_W-1:0] Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              req_overflow,
  output logic              data_overflow,
  output logic              busy
);

  localparam int RA_W  = $clog2(REQ_DEPTH);
  localparam int DA_W  = $clog2(DATA_DEPTH);
  localparam int REQ_W = ADDR_W + LEN_W;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t r_state, w_state_nxt;

  logic [RA_W:0]       r_req_wr, r_req_rd;
  logic [REQ_W-1:0]    r_req_mem [REQ_DEPTH];
  logic [DA_W:0]       r_data_wr, r_data_rd;
  logic [DATA_W-1:0]   r_data_mem [DATA_DEPTH];

  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_cnt;
  logic [LEN_W-1:0]    r_last_idx;
  logic                r_req_ovf;
  logic                r_data_ovf;

  logic                w_req_empty, w_req_full, w_req_push, w_req_pop;
  logic                w_data_empty, w_data_full, w_data_push, w_data_pop;
  logic [REQ_W-1:0]    w_req_head;
  logic                w_burst;
  logic                w_last;

  assign w_req_empty  = (r_req_wr == r_req_rd);
  assign w_req_full   = (r_req_wr[RA_W] != r_req_rd[RA_W]) &&
                        (r_req_wr[RA_W-1:0] == r_req_rd[RA_W-1:0]);
  assign w_data_empty = (r_data_wr == r_data_rd);
  assign w_data_full  = (r_data_wr[DA_W] != r_data_rd[DA_W]) &&
                        (r_data_wr[DA_W-1:0] == r_data_rd[DA_W-1:0]);

  assign w_burst    = (r_state == S_BURST);
  assign w_req_head = r_req_mem[r_req_rd[RA_W-1:0]];
  assign w_last     = w_burst && (r_cnt == r_last_idx);

  assign w_req_pop  = (r_state == S_IDLE) && !w_req_empty;
  assign w_data_pop = w_burst && !w_data_empty && out_ready;
  // A full FIFO still takes a push when the same edge frees a slot.
  assign w_req_push  = Valid_Addr && (!w_req_full  || w_req_pop);
  assign w_data_push = Valid_Data && (!w_data_full || w_data_pop);

  always_ff @(posedge clk) begin
    if (w_req_push)  r_req_mem[r_req_wr[RA_W-1:0]]   <= {Address, Length};
    if (w_data_push) r_data_mem[r_data_wr[DA_W-1:0]] <= Data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_wr   <= '0;
      r_req_rd   <= '0;
      r_data_wr  <= '0;
      r_data_rd  <= '0;
      r_req_ovf  <= 1'b0;
      r_data_ovf <= 1'b0;
    end else begin
      if (w_req_push)  r_req_wr  <= r_req_wr  + (RA_W+1)'(1);
      if (w_req_pop)   r_req_rd  <= r_req_rd  + (RA_W+1)'(1);
      if (w_data_push) r_data_wr <= r_data_wr + (DA_W+1)'(1);
      if (w_data_pop)  r_data_rd <= r_data_rd + (DA_W+1)'(1);
      if (Valid_Addr && !w_req_push)  r_req_ovf  <= 1'b1;
      if (Valid_Data && !w_data_push) r_data_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req_pop) w_state_nxt = S_BURST;
      S_BURST: if (w_data_pop && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_last_idx <= '0;
    end else if (w_req_pop) begin
      r_base     <= w_req_head[REQ_W-1:LEN_W];
      r_cnt      <= '0;
      r_last_idx <= w_req_head[LEN_W-1:0];
    end else if (w_data_pop) begin
      r_cnt      <= r_cnt + LEN_W'(1);
    end
  end

  assign out_valid     = w_burst && !w_data_empty;
  assign out_last      = w_last;
  assign out_addr      = r_base + ADDR_W'(r_cnt);
  // Gate the head so an empty FIFO reads as zero instead of stale storage.
  assign out_data      = w_data_empty ? '0 : r_data_mem[r_data_rd[DA_W-1:0]];
  assign req_overflow  = r_req_ovf;
  assign data_overflow = r_data_ovf;
  assign busy          = w_burst || !w_req_empty || !w_data_empty;

endmodule

// File: tb/tb_ab_req_merger.sv
// Directed bench for ab_req_merger: cycle-exact stimulus, hand-computed beats.
module tb_ab_req_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_Addr;
  logic [11:0] Address;
  logic [3:0]  Length;
  logic        Valid_Data;
  logic [23:0] Data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addr;
  logic [23:0] out_data;
  logic        out_last;
  logic        req_overflow;
  logic        data_overflow;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  ab_req_merger #(
    .ADDR_W(12), .LEN_W(4), .DATA_W(24), .REQ_DEPTH(4), .DATA_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .Valid_Addr(Valid_Addr), .Address(Address), .Length(Length),
    .Valid_Data(Valid_Data), .Data(Data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .req_overflow(req_overflow), .data_overflow(data_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".addr"},  32'(out_addr),  a);
    chk({tag, ".data"},  32'(out_data),  d);
    chk({tag, ".last"},  32'(out_last),  l);
  endtask

  task automatic idle(input string tag, input logic [31:0] b);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".last"},  32'(out_last),  32'd0);
    chk({tag, ".busy"},  32'(busy),      b);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(out_valid),     32'd0);
    chk({tag, ".last"},  32'(out_last),      32'd0);
    chk({tag, ".addr"},  32'(out_addr),      32'd0);
    chk({tag, ".data"},  32'(out_data),      32'd0);
    chk({tag, ".rovf"},  32'(req_overflow),  32'd0);
    chk({tag, ".dovf"},  32'(data_overflow), 32'd0);
    chk({tag, ".busy"},  32'(busy),          32'd0);
  endtask

  task automatic wait_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] l);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!out_valid && k < 10);
    beat(tag, a, d, l);
  endtask

  initial begin
    rst = 1'b1; Valid_Addr = 1'b0; Address = '0; Length = '0;
    Valid_Data = 1'b0; Data = '0; out_ready = 1'b1;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;

    // single burst 0x100, 4 beats, out_ready held high
    tick();
    Valid_Addr = 1'b1; Address = 12'h100; Length = 4'd3;
    tick();
    idle("sb.pre", 32'd1);
    Valid_Addr = 1'b0; Valid_Data = 1'b1; Data = 24'hA00001;
    for (int i = 0; i < 4; i++) begin
      tick();
      beat($sformatf("sb%0d", i), 32'h100 + 32'(i), 32'hA00001 + 32'(i), 32'(i == 3));
      if (i < 3) Data = 24'hA00002 + 24'(i);
      else       Valid_Data = 1'b0;
    end
    tick();
    idle("sb.post", 32'd0);

    // data arrives before its request
    tick();
    Valid_Data = 1'b1; Data = 24'h000011;
    tick();
    Data = 24'h000022;
    tick();
    Valid_Data = 1'b0;
    tick();
    idle("df.wait", 32'd1);
    tick();
    tick();
    Valid_Addr = 1'b1; Address = 12'h020; Length = 4'd1;
    tick();
    Valid_Addr = 1'b0;
    chk("df.nopop.valid", 32'(out_valid), 32'd0);
    tick();
    beat("df0", 32'h020, 32'h000011, 32'd0);
    tick();
    beat("df1", 32'h021, 32'h000022, 32'd1);
    tick();
    idle("df.post", 32'd0);

    // address wrap with out_ready toggling
    tick();
    out_ready = 1'b0;
    Valid_Addr = 1'b1; Address = 12'hFFE; Length = 4'd3;
    Valid_Data = 1'b1; Data = 24'hB00001;
    tick();
    chk("wr.idle.valid", 32'(out_valid), 32'd0);
    Valid_Addr = 1'b0; Data = 24'hB00002;
    tick();
    beat("wr0", 32'hFFE, 32'hB00001, 32'd0);
    Data = 24'hB00003; out_ready = 1'b1;
    tick();
    beat("wr1", 32'hFFF, 32'hB00002, 32'd0);
    Data = 24'hB00004; out_ready = 1'b0;
    tick();
    beat("wr1.hold", 32'hFFF, 32'hB00002, 32'd0);
    Valid_Data = 1'b0; out_ready = 1'b1;
    tick();
    beat("wr2", 32'h000, 32'hB00003, 32'd0);
    out_ready = 1'b0;
    tick();
    beat("wr2.hold", 32'h000, 32'hB00003, 32'd0);
    out_ready = 1'b1;
    tick();
    beat("wr3", 32'h001, 32'hB00004, 32'd1);
    out_ready = 1'b0;
    tick();
    beat("wr3.hold", 32'h001, 32'hB00004, 32'd1);
    out_ready = 1'b1;
    tick();
    idle("wr.post", 32'd0);

    // request overflow: first request goes in flight, next four fill, sixth drops
    tick();
    Valid_Addr = 1'b1; Address = 12'h200; Length = 4'd0;
    for (int i = 1; i < 6; i++) begin
      tick();
      if (i == 5) chk("ro.before", 32'(req_overflow), 32'd0);
      Address = 12'h200 + 12'(i);
    end
    tick();
    chk("ro.set", 32'(req_overflow), 32'd1);
    Valid_Addr = 1'b0; Valid_Data = 1'b1; Data = 24'hC00000;
    tick();
    beat("ro0", 32'h200, 32'hC00000, 32'd1);
    Data = 24'hC00001;
    tick();
    chk("ro.gap0", 32'(out_valid), 32'd0);
    Data = 24'hC00002;
    tick();
    beat("ro1", 32'h201, 32'hC00001, 32'd1);
    Data = 24'hC00003;
    tick();
    chk("ro.gap1", 32'(out_valid), 32'd0);
    Data = 24'hC00004;
    tick();
    beat("ro2", 32'h202, 32'hC00002, 32'd1);
    Valid_Data = 1'b0;
    wait_beat("ro3", 32'h203, 32'hC00003, 32'd1);
    wait_beat("ro4", 32'h204, 32'hC00004, 32'd1);
    tick();
    idle("ro.post", 32'd0);
    chk("ro.sticky", 32'(req_overflow), 32'd1);
    chk("ro.dovf", 32'(data_overflow), 32'd0);

    // full data FIFO with a push on a pop edge
    tick();
    out_ready = 1'b0;
    Valid_Addr = 1'b1; Address = 12'h300; Length = 4'd15;
    Valid_Data = 1'b1; Data = 24'hD00000;
    for (int i = 1; i < 16; i++) begin
      tick();
      Valid_Addr = 1'b0; Data = 24'hD00000 + 24'(i);
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      beat($sformatf("fp%0d", j), 32'h300 + 32'(j), 32'hD00000 + 32'(j), 32'(j == 15));
      if (j == 0) begin
        out_ready = 1'b1; Data = 24'hD00010;
      end else if (j == 1) begin
        Valid_Data = 1'b0;
        chk("fp.dovf", 32'(data_overflow), 32'd0);
      end
    end
    tick();
    Valid_Addr = 1'b1; Address = 12'h3A0; Length = 4'd0;
    tick();
    Valid_Addr = 1'b0;
    wait_beat("fp.extra", 32'h3A0, 32'hD00010, 32'd1);
    tick();
    idle("fp.post", 32'd0);

    // full data FIFO with no pop: seventeenth beat is dropped
    tick();
    out_ready = 1'b0;
    Valid_Addr = 1'b1; Address = 12'h3B0; Length = 4'd15;
    Valid_Data = 1'b1; Data = 24'hE00000;
    for (int i = 1; i < 17; i++) begin
      tick();
      if (i == 16) chk("do.before", 32'(data_overflow), 32'd0);
      Valid_Addr = 1'b0; Data = 24'hE00000 + 24'(i);
    end
    tick();
    chk("do.set", 32'(data_overflow), 32'd1);
    beat("do.head", 32'h3B0, 32'hE00000, 32'd0);
    Valid_Data = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset("do.rst");
    tick();
    rst = 1'b0;

    // asynchronous reset in the middle of an 8-beat burst
    tick();
    out_ready = 1'b1;
    Valid_Addr = 1'b1; Address = 12'h080; Length = 4'd7;
    Valid_Data = 1'b1; Data = 24'hF00000;
    tick();
    Valid_Addr = 1'b0; Data = 24'hF00001;
    tick();
    beat("mr0", 32'h080, 32'hF00000, 32'd0);
    Data = 24'hF00002;
    tick();
    beat("mr1", 32'h081, 32'hF00001, 32'd0);
    Data = 24'hF00003;
    tick();
    beat("mr2", 32'h082, 32'hF00002, 32'd0);
    #2 rst = 1'b1;
    Valid_Data = 1'b0;
    #1 chk_reset("mr.rst");
    tick();
    rst = 1'b0;
    tick();
    Valid_Addr = 1'b1; Address = 12'h040; Length = 4'd0;
    Valid_Data = 1'b1; Data = 24'h5A5A5A;
    tick();
    Valid_Addr = 1'b0; Valid_Data = 1'b0;
    wait_beat("mr.new", 32'h040, 32'h5A5A5A, 32'd1);
    tick();
    idle("mr.post", 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
